// File: rtl/div_unit.sv
// Multi-cycle signed divider for the MIPS datapath HI/LO path.
// Restoring shift-subtract on operand magnitudes (one quotient bit per
// clock), followed by a single sign-correction cycle. divHi holds the
// remainder and divLo the quotient, as in MIPS DIV.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] divHi,
  output logic [WIDTH-1:0] divLo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RUN  = 3'd1;
  localparam logic [2:0] FIX  = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ZERO = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsMag;
  logic             signA;
  logic             signB;

  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH-1:0] remShift;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic             fits;
  logic [WIDTH-1:0] quoFinal;
  logic [WIDTH-1:0] remFinal;

  // Operand magnitudes; -2^(WIDTH-1) maps onto its own unsigned bit pattern.
  always_comb begin
    dividendMag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    divisorMag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  end

  // One restoring step: pull the next dividend bit in and subtract when it fits.
  // rem stays below |divisor| <= 2^(WIDTH-1), so the shift never loses a bit.
  always_comb begin
    remShift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    fits     = (remShift >= dvsMag);
    remNext  = fits ? (remShift - dvsMag) : remShift;
    quoNext  = {quo[WIDTH-2:0], fits};
  end

  // Sign correction: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    quoFinal = (signA ^ signB) ? (~quo + 1'b1) : quo;
    remFinal = signA ? (~rem + 1'b1) : rem;
  end

  // Control FSM plus datapath registers; results only move in FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsMag  <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      divHi   <= '0;
      divLo   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            quo     <= dividendMag;
            dvsMag  <= divisorMag;
            signA   <= dividend[WIDTH-1];
            signB   <= divisor[WIDTH-1];
            rem     <= '0;
            count   <= '0;
            divZero <= 1'b0;
            busy    <= 1'b1;
            state   <= (divisor == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          rem   <= remNext;
          quo   <= quoNext;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          divLo <= quoFinal;
          divHi <= remFinal;
          done  <= 1'b1;
          state <= DONE;
        end
        ZERO: begin
          divZero <= 1'b1;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases followed by
// random operands, all checked against a 64-bit integer reference model.
module tb_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [31:0] divHi;
  logic [31:0] divLo;

  int errors = 0;
  int checks = 0;

  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .divZero  (divZero),
    .divHi    (divHi),
    .divLo    (divLo)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: signed 64-bit division truncates toward zero and the remainder
  // keeps the dividend's sign; -2^31 / -1 wraps back to 0x80000000.
  function automatic void refDivide(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = 32'(sa / sb);
    r = 32'(sa % sb);
  endfunction

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one operation, wait boundedly for done and check latency and results.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b);
    int cycles;
    int expLat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    checkOutput({tag, " busy after start"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, " divZero cleared"}, {31'd0, divZero}, 32'd0);
    if (b == 32'd0) begin
      expLat = 1;
    end else begin
      expLat = 33;
      refDivide(a, b, expLo, expHi);
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (done !== 1'b1 && cycles < 33) begin
        checkOutput({tag, " stable hi"}, divHi, divHi);
      end
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, " divLo"}, divLo, expLo);
    checkOutput({tag, " divHi"}, divHi, expHi);
    checkOutput({tag, " divZero"}, {31'd0, divZero}, {31'd0, (b == 32'd0)});
    checkOutput({tag, " busy in done"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, " done pulse ends"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " busy ends"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int doneCount;
    int firstDone;
    int busyOk;
    logic [31:0] ra;
    logic [31:0] rb;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset divZero", {31'd0, divZero}, 32'd0);
    checkOutput("reset divHi", divHi, 32'd0);
    checkOutput("reset divLo", divLo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Sign combinations.
    applyStimulus("100/7", 32'd100, 32'd7);
    checkOutput("100/7 literal lo", divLo, 32'h0000000E);
    checkOutput("100/7 literal hi", divHi, 32'h00000002);

    // Divide by zero keeps previous results and leaves divZero set until the next start.
    applyStimulus("55/0", 32'd55, 32'd0);
    checkOutput("55/0 keeps lo", divLo, 32'd14);
    checkOutput("55/0 keeps hi", divHi, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("divZero sticky", {31'd0, divZero}, 32'd1);

    applyStimulus("-100/7", 32'hFFFFFF9C, 32'd7);
    checkOutput("-100/7 literal lo", divLo, 32'hFFFFFFF2);
    checkOutput("-100/7 literal hi", divHi, 32'hFFFFFFFE);
    applyStimulus("100/-7", 32'd100, 32'hFFFFFFF9);
    applyStimulus("-100/-7", 32'hFFFFFF9C, 32'hFFFFFFF9);

    // Extremes of the signed range.
    applyStimulus("min/-1", 32'h80000000, 32'hFFFFFFFF);
    checkOutput("min/-1 literal lo", divLo, 32'h80000000);
    checkOutput("min/-1 literal hi", divHi, 32'h00000000);
    applyStimulus("-1/min", 32'hFFFFFFFF, 32'h80000000);
    checkOutput("-1/min literal hi", divHi, 32'hFFFFFFFF);
    applyStimulus("min/min", 32'h80000000, 32'h80000000);
    applyStimulus("max/1", 32'h7FFFFFFF, 32'd1);

    // A second start during RUN must be ignored.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    doneCount = 0;
    firstDone = 0;
    busyOk    = 1;
    for (int n = 1; n <= 45; n++) begin
      if (n == 10) begin
        dividend = 32'd9;
        divisor  = 32'd9;
        start    = 1'b1;
      end
      @(posedge clk); #1;
      if (n == 10) start = 1'b0;
      if (done === 1'b1) begin
        doneCount++;
        if (firstDone == 0) firstDone = n;
      end
      if (n <= 33 && busy !== 1'b1) busyOk = 0;
    end
    checkOutput("busy start ignored one done", 32'(doneCount), 32'd1);
    checkOutput("busy start latency", 32'(firstDone), 32'd33);
    checkOutput("busy start held busy", 32'(busyOk), 32'd1);
    checkOutput("busy start divLo", divLo, 32'd333);
    checkOutput("busy start divHi", divHi, 32'd1);

    // Reset in the middle of an operation abandons it.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset divLo", divLo, 32'd0);
    checkOutput("midreset divHi", divHi, 32'd0);
    checkOutput("midreset done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    doneCount = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneCount++;
    end
    checkOutput("midreset no done", 32'(doneCount), 32'd0);
    expHi = '0;
    expLo = '0;
    applyStimulus("9/9 after reset", 32'd9, 32'd9);

    // Random operands, biased toward small divisors and the occasional zero.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 1000));
        default: rb = (i % 8 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      applyStimulus($sformatf("rand%0d", i), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
